debounce_pulse: RTL and testbench

- Front-end conditioner for board push-buttons and slow mechanical inputs.
- Synchronises an asynchronous level, rejects bounce and glitches shorter than a programmable window, and emits a debounced level plus single-cycle press/release strobes.
- Complements stretch_pulse: it turns a long, noisy human-scale level into clean clock-domain events, where stretch_pulse turns short events into long, visible levels.
- Sits between the DE0 key pins and control logic (pattern select, SPI test triggers).

---
 rtl/debounce_pulse.sv | 125 ++++++++++++
 tb/tb_debounce_pulse.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, registered level plus press/release strobes.
// Optional auto-repeat of press strobes while held: define DEBOUNCE_PULSE_AUTO_REPEAT_EN.
module debounce_pulse #(
  parameter int unsigned SYSTEM_CLOCK  = 50000000,
  parameter int unsigned DEBOUNCE_TIME = SYSTEM_CLOCK / 100,
  parameter int unsigned IN_ACTIVE_LOW = 1,
  parameter int unsigned REPEAT_DELAY  = SYSTEM_CLOCK / 2,
  parameter int unsigned REPEAT_PERIOD = SYSTEM_CLOCK / 10
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic in_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned MAX_A   = (DEBOUNCE_TIME > REPEAT_DELAY) ? DEBOUNCE_TIME : REPEAT_DELAY;
  localparam int unsigned MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic        INACT   = (IN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEBOUNCE_TIME - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             s1, s2;
  logic             act;
  logic             level_next, press_next, release_next;

  assign act = s2 ^ INACT;

  // Synchroniser, state register and registered outputs
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      s1        <= INACT;
      s2        <= INACT;
      state     <= IDLE;
      cnt       <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      s1        <= in_i;
      s2        <= s1;
      state     <= state_next;
      cnt       <= cnt_next;
      level_o   <= level_next;
      press_o   <= press_next;
      release_o <= release_next;
    end
  end

  // Next-state, counter and strobe decisions, all driven by act
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      IDLE: begin
        if (act) begin
          state_next = PRESS_WAIT;
          cnt_next   = DEB_LOAD;
        end
      end
      PRESS_WAIT: begin
        if (!act) begin
          state_next = IDLE;
        end else if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          state_next = PRESSED;
          press_next = 1'b1;
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
          cnt_next   = CNT_W'(REPEAT_DELAY - 1);
`endif
        end
      end
      PRESSED: begin
        if (!act) begin
          state_next = RELEASE_WAIT;
          cnt_next   = DEB_LOAD;
        end else begin
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
          if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
          end else begin
            press_next = 1'b1;
            cnt_next   = CNT_W'(REPEAT_PERIOD - 1);
          end
`else
          cnt_next = cnt;
`endif
        end
      end
      RELEASE_WAIT: begin
        if (act) begin
          state_next = PRESSED;
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
          cnt_next   = CNT_W'(REPEAT_DELAY - 1);
`endif
        end else if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          state_next   = IDLE;
          release_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: vector table, hand-written corner sequences and random stimulus against a run-length model.
// Instance a is active-low, instance b active-high and driven with the inverted input, so both expect identical outputs.
module tb_debounce_pulse;

  localparam int unsigned DT = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;

  logic clk;
  logic rst_n;
  logic in_a, in_b;
  logic lvl_a, pr_a, rl_a;
  logic lvl_b, pr_b, rl_b;

  int errors = 0;
  int checks = 0;

  debounce_pulse #(
    .SYSTEM_CLOCK(1000), .DEBOUNCE_TIME(DT), .IN_ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .in_i(in_a),
    .level_o(lvl_a), .press_o(pr_a), .release_o(rl_a)
  );

  debounce_pulse #(
    .SYSTEM_CLOCK(1000), .DEBOUNCE_TIME(DT), .IN_ACTIVE_LOW(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .in_i(in_b),
    .level_o(lvl_b), .press_o(pr_b), .release_o(rl_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: synchroniser delay plus run-length counting of the sampled button state
  logic m_p1, m_p2, m_level, m_press, m_rel;
  int   m_run;
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
  int   m_held;
`endif

  task automatic model_edge();
    logic a;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (!rst_n) begin
      m_p1 = 1'b0; m_p2 = 1'b0; m_level = 1'b0; m_run = 0;
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
      m_held = 0;
`endif
      return;
    end
    a    = m_p2;
    m_p2 = m_p1;
    m_p1 = ~in_a;
    if (!m_level) begin
      if (a) begin
        m_run++;
        if (m_run == int'(DT) + 1) begin
          m_level = 1'b1; m_press = 1'b1; m_run = 0;
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
          m_held = 0;
`endif
        end
      end else begin
        m_run = 0;
      end
    end else if (!a) begin
      m_run++;
      if (m_run == int'(DT) + 1) begin
        m_level = 1'b0; m_rel = 1'b1; m_run = 0;
      end
    end else if (m_run > 0) begin
      m_run = 0;
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
      m_held = 0;
`endif
    end else begin
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
      m_held++;
      if (m_held >= int'(RD) && ((m_held - int'(RD)) % int'(RP)) == 0) m_press = 1'b1;
`endif
    end
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {level,press,release}=%b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare both instances just after it
  task automatic step(input logic r, input logic x);
    rst_n = r;
    in_a  = x;
    in_b  = ~x;
    @(posedge clk);
    model_edge();
    #1;
    chk("model_a", {lvl_a, pr_a, rl_a}, {m_level, m_press, m_rel});
    chk("model_b", {lvl_b, pr_b, rl_b}, {m_level, m_press, m_rel});
  endtask

  typedef struct {
    logic       rst_n;
    logic       in;
    logic [2:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   presses;
    int   first_idx;

    rst_n = 1'b0;
    in_a  = 1'b1;
    in_b  = 1'b0;

    // Reset, clean press, glitch while pressed, clean release (a-polarity: 0 = pressed)
    for (int i = 0; i < 2; i++) tbl.push_back('{1'b0, 1'b1, 3'b000});
    for (int i = 0; i < 6; i++) tbl.push_back('{1'b1, 1'b0, 3'b000});
    tbl.push_back('{1'b1, 1'b0, 3'b110});
    tbl.push_back('{1'b1, 1'b0, 3'b100});
    for (int i = 0; i < 2; i++) tbl.push_back('{1'b1, 1'b1, 3'b100});
    for (int i = 0; i < 6; i++) tbl.push_back('{1'b1, 1'b0, 3'b100});
    for (int i = 0; i < 6; i++) tbl.push_back('{1'b1, 1'b1, 3'b100});
    tbl.push_back('{1'b1, 1'b1, 3'b001});
    tbl.push_back('{1'b1, 1'b1, 3'b000});

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].in);
      chk("vec_a", {lvl_a, pr_a, rl_a}, tbl[i].exp);
      chk("vec_b", {lvl_b, pr_b, rl_b}, tbl[i].exp);
    end

    // Bounce faster than the window never yields a strobe
    presses = 0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) begin step(1'b1, 1'b0); presses += int'(pr_a) + int'(rl_a) + int'(lvl_a); end
      for (int i = 0; i < 3; i++) begin step(1'b1, 1'b1); presses += int'(pr_a) + int'(rl_a) + int'(lvl_a); end
    end
    chk_int("bounce_quiet", presses, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);

    // Reset mid PRESS_WAIT, then re-debounce the still-held input
    first_idx = -1;
    for (int i = 0; i < 16; i++) begin
      step((i == 4) ? 1'b0 : 1'b1, 1'b0);
      if (i == 4) chk("reset_mid_press", {lvl_a, pr_a, rl_a}, 3'b000);
      if (pr_a && first_idx < 0) first_idx = i;
    end
    chk_int("press_after_reset_idx", first_idx, 11);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);

    // Long hold: auto-repeat strobes at 6,16,21,...,41 or a single press
    presses   = 0;
    first_idx = -1;
    for (int i = 0; i < 42; i++) begin
      step(1'b1, 1'b0);
      if (pr_a) begin
        presses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    chk_int("first_press_idx", first_idx, int'(DT) + 2);
`ifdef DEBOUNCE_PULSE_AUTO_REPEAT_EN
    chk_int("hold_press_count", presses, 7);
`else
    chk_int("hold_press_count", presses, 1);
`endif
    chk("hold_level", {lvl_a, 2'b00}, 3'b100);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    chk("released", {lvl_a, pr_a, rl_a}, 3'b000);

    // Random bursts of varying length with occasional one-cycle resets
    for (int k = 0; k < 400; k++) begin
      logic x;
      int   len;
      x   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) step(($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1, x);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
